// File: rtl/sync_fifo_pkg.sv
// Sizing helpers and error-flag layout shared by the single-clock FIFO controller.
package sync_fifo_pkg;

    localparam int ERR_W         = 2;
    localparam int ERR_OVERFLOW  = 0;
    localparam int ERR_UNDERFLOW = 1;

    function automatic int fifo_aw(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int fifo_lw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dualport_ram_sync.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module dualport_ram_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage and read register carry no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with level, threshold and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_AFULL  = FIFO_DEPTH - 1,
    parameter int FIFO_AEMPTY = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic                            rd_en,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            rd_data_vld,
    output logic                            full,
    output logic                            empty,
    output logic                            afull,
    output logic                            aempty,
    output logic [fifo_lw(FIFO_DEPTH)-1:0]  level,
    output logic                            overflow,
    output logic                            underflow,
    input  logic                            err_clr
);

    localparam int ADDR_WIDTH = fifo_aw(FIFO_DEPTH);
    localparam int LW         = fifo_lw(FIFO_DEPTH);

    localparam logic [ADDR_WIDTH-1:0] PTR_LAST   = ADDR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [LW-1:0]         LVL_FULL   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]         LVL_AFULL  = LW'(FIFO_AFULL);
    localparam logic [LW-1:0]         LVL_AEMPTY = LW'(FIFO_AEMPTY);

    generate
        if (FIFO_DEPTH < 2) begin : g_bad_depth
            $error("sync_fifo_ctrl: FIFO_DEPTH must be at least 2");
        end
        if (FIFO_AFULL > FIFO_DEPTH) begin : g_bad_afull
            $error("sync_fifo_ctrl: FIFO_AFULL must not exceed FIFO_DEPTH");
        end
        if (FIFO_AEMPTY >= FIFO_AFULL) begin : g_bad_aempty
            $error("sync_fifo_ctrl: FIFO_AEMPTY must be below FIFO_AFULL");
        end
    endgenerate

    logic                  wr_vld;
    logic                  rd_vld;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  ram_rd_en;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [LW-1:0]         level_nxt;
    logic                  empty_nxt;
    logic [ERR_W-1:0]      err_q;
    logic [ERR_W-1:0]      err_set;

    assign wr_vld = wr_en & ~full;
    assign rd_vld = rd_en & ~empty;

    always_comb begin
        // NOTE: default assigned first so every path drives level_nxt and no latch is inferred.
        level_nxt = level;
        case ({wr_vld, rd_vld})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // Pointers wrap by compare so non-power-of-two depths never index past the array.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= 1'b0;
            aempty <= 1'b1;
        end else begin
            if (wr_vld) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (ram_rd_en) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            level  <= level_nxt;
            full   <= (level_nxt == LVL_FULL);
            empty  <= empty_nxt;
            afull  <= (level_nxt >= LVL_AFULL);
            aempty <= (level_nxt <= LVL_AEMPTY);
        end
    end

    assign err_set[ERR_OVERFLOW]  = wr_en & full;
    assign err_set[ERR_UNDERFLOW] = rd_en & empty;

    // A new error in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= (err_q & {ERR_W{~err_clr}}) | err_set;
        end
    end

    assign overflow  = err_q[ERR_OVERFLOW];
    assign underflow = err_q[ERR_UNDERFLOW];

    dualport_ram_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_vld),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // The RAM read register doubles as the head register; level includes the word held there.
    logic          head_vld;
    logic          head_vld_nxt;
    logic [LW-1:0] ram_cnt;

    assign ram_cnt      = level - LW'(head_vld);
    assign ram_rd_en    = (ram_cnt != '0) && (!head_vld || rd_vld);
    assign head_vld_nxt = ram_rd_en | (head_vld & ~rd_vld);
    assign empty_nxt    = ~head_vld_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_vld <= 1'b0;
        end else begin
            head_vld <= head_vld_nxt;
        end
    end

    assign rd_data     = head_vld ? ram_q : '0;
    assign rd_data_vld = head_vld;
`else
    // rd_seen masks the unreset RAM read register until the first accepted read.
    logic rd_pulse;
    logic rd_seen;

    assign ram_rd_en = rd_vld;
    assign empty_nxt = (level_nxt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pulse <= 1'b0;
            rd_seen  <= 1'b0;
        end else begin
            rd_pulse <= rd_vld;
            rd_seen  <= rd_seen | rd_vld;
        end
    end

    assign rd_data     = rd_seen ? ram_q : '0;
    assign rd_data_vld = rd_pulse;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl (DEPTH=6, AFULL=5, AEMPTY=1) against a queue model.
// Covers standard mode by default and FWFT mode when SYNC_FIFO_FWFT_EN is defined.
module tb_sync_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 6;
    localparam int AF    = 5;
    localparam int AE    = 1;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_data_vld;
    logic          full;
    logic          empty;
    logic          afull;
    logic          aempty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;
    logic          err_clr;

    sync_fifo_ctrl #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .FIFO_AFULL  (AF),
        .FIFO_AEMPTY (AE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_data_vld (rd_data_vld),
        .full        (full),
        .empty       (empty),
        .afull       (afull),
        .aempty      (aempty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: ordered contents with the edge each word was written on.
    typedef struct {
        logic [DW-1:0] data;
        int            edge_no;
    } entry_t;

    entry_t        mq[$];
    int            edge_cnt = 0;
    logic          m_ovf    = 1'b0;
    logic          m_udf    = 1'b0;
    logic          m_vld    = 1'b0;
    logic [DW-1:0] m_data   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whether the head word is readable right now.
    function automatic bit head_visible();
`ifdef SYNC_FIFO_FWFT_EN
        return (mq.size() > 0) && (mq[0].edge_no + 1 <= edge_cnt);
`else
        return mq.size() > 0;
`endif
    endfunction

    task automatic check_all();
        logic [DW-1:0] exp_data;
        logic          exp_vld;
`ifdef SYNC_FIFO_FWFT_EN
        exp_vld  = head_visible();
        exp_data = exp_vld ? mq[0].data : '0;
`else
        exp_vld  = m_vld;
        exp_data = m_data;
`endif
        check("level", level, mq.size());
        check("full", full, mq.size() == DEPTH);
        check("empty", empty, !head_visible());
        check("afull", afull, mq.size() >= AF);
        check("aempty", aempty, mq.size() <= AE);
        check("rd_data", rd_data, exp_data);
        check("rd_data_vld", rd_data_vld, exp_vld);
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_udf);
    endtask

    // One clock: drive, advance the model across the edge, then compare every output.
    task automatic cycle(input bit rst, input bit wr, input logic [DW-1:0] wd,
                         input bit rd, input bit clr);
        bit     full_m;
        bit     empty_m;
        entry_t e;
        rst_n   = !rst;
        wr_en   = wr;
        wr_data = wd;
        rd_en   = rd;
        err_clr = clr;
        full_m  = (mq.size() == DEPTH);
        empty_m = !head_visible();
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_vld  = 1'b0;
            m_data = '0;
        end else begin
            m_ovf = (m_ovf && !clr) || (wr && full_m);
            m_udf = (m_udf && !clr) || (rd && empty_m);
            m_vld = rd && !empty_m;
            if (m_vld) begin
                e      = mq.pop_front();
                m_data = e.data;
            end
            if (wr && !full_m) begin
                mq.push_back('{data: wd, edge_no: edge_cnt});
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        bit            w;
        bit            r;
        bit            c;
        bit            x;
        logic [DW-1:0] d;

        cycle(1, 0, 8'h00, 0, 0);
        cycle(1, 0, 8'h00, 0, 0);
        cycle(0, 0, 8'h00, 0, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_aempty", aempty, 1);
        check("rst_rd_data", rd_data, 0);

`ifdef SYNC_FIFO_FWFT_EN
        cycle(0, 1, 8'hA5, 0, 0);
        check("fwft_edge1_empty", empty, 1);
        cycle(0, 0, 8'h00, 0, 0);
        check("fwft_edge2_empty", empty, 0);
        check("fwft_edge2_data", rd_data, 8'hA5);
        cycle(0, 0, 8'h00, 1, 0);
        for (int i = 1; i <= 4; i++) cycle(0, 1, DW'(i), 0, 0);
        cycle(0, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            check("fwft_b2b_data", rd_data, i);
            check("fwft_b2b_vld", rd_data_vld, 1);
            cycle(0, 0, 8'h00, 1, 0);
        end
        check("fwft_drained_empty", empty, 1);
`else
        for (int i = 1; i <= 6; i++) begin
            cycle(0, 1, DW'(i), 0, 0);
            if (i == 5) check("afull_after5", afull, 1);
        end
        check("full_after6", full, 1);
        check("level_after6", level, 6);
        cycle(0, 1, 8'h07, 0, 0);
        check("ovf_7th_write", overflow, 1);
        check("level_stays6", level, 6);

        for (int i = 1; i <= 6; i++) begin
            cycle(0, 0, 8'h00, 1, 0);
            check("drain_data", rd_data, i);
            check("drain_vld", rd_data_vld, 1);
        end
        check("empty_after_drain", empty, 1);
        cycle(0, 0, 8'h00, 1, 0);
        check("udf_extra_read", underflow, 1);
        cycle(0, 0, 8'h00, 0, 1);
        check("clr_ovf", overflow, 0);
        check("clr_udf", underflow, 0);

        for (int i = 0; i < 3; i++) cycle(0, 1, DW'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 1, DW'($urandom), 1, 0);
        check("wrap_level3", level, 3);

        while (mq.size() < DEPTH) cycle(0, 1, DW'($urandom), 0, 0);
        cycle(0, 1, 8'hEE, 1, 0);
        check("both_full_level", level, 5);
        check("both_full_ovf", overflow, 1);
        while (mq.size() > 0) cycle(0, 0, 8'h00, 1, 0);
        cycle(0, 1, 8'h3C, 1, 0);
        check("both_empty_level", level, 1);
        check("both_empty_udf", underflow, 1);
        cycle(0, 0, 8'h00, 0, 1);
        check("clr_both_ovf", overflow, 0);
        check("clr_both_udf", underflow, 0);

        cycle(0, 0, 8'h00, 1, 0);
        cycle(0, 0, 8'h00, 1, 1);
        check("set_wins_udf", underflow, 1);
        cycle(0, 0, 8'h00, 0, 1);

        for (int i = 0; i < 4; i++) cycle(0, 1, DW'(8'h80 + i), 0, 0);
        cycle(1, 0, 8'h00, 0, 0);
        check("midrst_level", level, 0);
        check("midrst_empty", empty, 1);
        check("midrst_rd_data", rd_data, 0);
        cycle(0, 1, 8'h5A, 0, 0);
        cycle(0, 0, 8'h00, 1, 0);
        check("midrst_fresh_data", rd_data, 8'h5A);
`endif

        for (int i = 0; i < 600; i++) begin
            w = ($urandom_range(99) < 55);
            r = ($urandom_range(99) < 50);
            c = ($urandom_range(99) < 5);
            x = ($urandom_range(99) < 2);
            d = DW'($urandom);
            cycle(x, w, d, r, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock parametrised FIFO: the same-clock successor to the team's async FIFO, used wherever producer and consumer share a domain. Supports any depth ≥ 2, including non-power-of-two depths, with wrap-aware pointers. Adds a fill-level output, registered programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. A compile-time first-word-fall-through (FWFT) read mode is also available.

## Interface
- DATA_WIDTH, 8, payload width in bits
- FIFO_DEPTH, 16, number of entries; any integer ≥ 2
- FIFO_AFULL, FIFO_DEPTH-1, afull asserts when level ≥ this value
- FIFO_AEMPTY, 1, aempty asserts when level ≤ this value
- clk  input  1  single clock; all logic on the rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- wr_en  input  1  write request
- wr_data  input  DATA_WIDTH  write payload
- rd_en  input  1  read request
- rd_data  output  DATA_WIDTH  read payload
- rd_data_vld  output  1  rd_data holds a valid popped word
- full / empty  output  1 each  registered occupancy flags
- afull / aempty  output  1 each  registered threshold flags
- level  output  $clog2(FIFO_DEPTH+1)  current occupancy
- overflow / underflow  output  1 each  sticky error flags
- err_clr  input  1  clears both sticky error flags

## Operation
- Accepted write: wr_vld = wr_en & ~full. Accepted read: rd_vld = rd_en & ~empty. Rejected requests cause no state change.
- Pointers are ADDR_WIDTH = $clog2(FIFO_DEPTH) bits wide. Each pointer wraps from FIFO_DEPTH-1 to 0 by compare, never by natural overflow.
- level changes per cycle: +1 on wr_vld only, -1 on rd_vld only, unchanged on both or neither.
- Flag definitions, all taken from the next-state level:
  - full = (level == FIFO_DEPTH)
  - empty = (level == 0)
  - afull = (level ≥ FIFO_AFULL)
  - aempty = (level ≤ FIFO_AEMPTY)
- Simultaneous requests:
  - When full: the read is accepted, the write is rejected, and overflow sets.
  - When empty: the write is accepted, the read is rejected, and underflow sets.
  - Otherwise: both are accepted and level is unchanged.
- overflow sets on wr_en & full. underflow sets on rd_en & empty. Both hold until err_clr. If err_clr and a new error occur in the same cycle, set wins.
- Reset values: level=0, empty=1, aempty=1, full=0, afull=0, rd_data=0, rd_data_vld=0, overflow=0, underflow=0. Pointers reset to 0.
- Reset asserted mid-operation discards all contents on that edge. RAM contents are not cleared.
- Elaboration errors: FIFO_AFULL > FIFO_DEPTH, or FIFO_AEMPTY ≥ FIFO_AFULL.

## Timing
- Standard mode:
  - rd_data is updated on the edge after rd_vld is sampled.
  - rd_data_vld is a one-cycle pulse coincident with that data.
  - rd_data holds its value when no read is accepted.
- Flags and level are registered and update on the same edge as the pointer move.
- Write-to-empty-deassert latency is 1 cycle. Full-rate writes and reads are sustained: one per cycle each, concurrently.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Undefined: standard mode, as described above.
- Defined: FWFT mode.
  - The head word is presented on rd_data while empty=0; rd_data_vld = ~empty.
  - rd_vld pops the displayed word; the next word is shown on the following cycle with no bubble.
  - A write into an empty FIFO becomes visible (empty=0) 2 edges after the write is sampled: one edge for the RAM write, one for the prefetch.
  - level counts the word held in the output register.
  - Reset clears the prefetch register valid bit.

## Structure
- Package sync_fifo_pkg holds:
  - function fifo_aw(depth) returning the pointer width
  - function fifo_lw(depth) returning the level width
  - shared error-flag localparams
- Sub-module dualport_ram_sync:
  - one write port and one read port, single clock
  - synchronous read, one-cycle latency
  - parameters DATA_WIDTH and ADDR_WIDTH, plus a DEPTH parameter
  - the controller instantiates it once

## Test plan
Configuration for all scenarios unless noted: DATA_WIDTH=8, FIFO_DEPTH=6, FIFO_AFULL=5, FIFO_AEMPTY=1.
- Reset, then idle: empty=1, aempty=1, level=0; all other outputs 0.
- Write 0x01..0x06 on consecutive cycles: after the 5th write afull=1; after the 6th full=1 and level=6. A 7th write sets overflow=1 and level stays 6.
- Read 6 words from full in standard mode: rd_data shows 0x01..0x06, one cycle after each rd_en, with rd_data_vld pulsing. After the last read empty=1. A further rd_en sets underflow=1.
- Wrap-around: 20 cycles of simultaneous wr_en/rd_en at level=3. level stays 3 and the data order is preserved across pointer wraps at index 5→0.
- Simultaneous requests at the boundaries:
  - wr_en&rd_en while full → level drops to 5, overflow=1.
  - wr_en&rd_en while empty → level becomes 1, underflow=1.
  - err_clr on the next cycle clears both flags.
- With SYNC_FIFO_FWFT_EN defined: write 0xA5 into an empty FIFO; rd_data=0xA5 and empty=0 two edges later. Back-to-back pops of 0x01..0x04 complete with no idle cycle between words.
